// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the eight-requester round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    function automatic logic [NUM_REQ-1:0] idx_to_oh(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set bit of req at or after ptr, wrapping.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    always_comb begin
        // Rotate so that bit 0 of rot is requester ptr; the lowest set bit is the winner.
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        any = |req;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        gnt_idx = ptr + off;
        gnt_oh  = any ? idx_to_oh(gnt_idx) : '0;
    end

endmodule

// File: rtl/rr_arb_8.sv
// Eight-requester round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arb_8
    import rr_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant_vld;

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        grant_vld = en & pick_any;
        // Gate with reset so the grant drops the instant reset is asserted.
        gnt       = (grant_vld && reset) ? pick_oh : '0;
        ptr_d     = grant_vld ? pick_idx + IDX_W'(1) : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_arb_8.sv
// Randomised scoreboard bench for rr_arb_8 against a scan-order reference model.
module tb_rr_arb_8;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       en;
    logic [7:0] gnt;

    rr_arb_8 dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    (en),
        .gnt   (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr   = 0;

    localparam int T_RST  = 0;
    localparam int T_ROT  = 1;
    localparam int T_EN   = 2;
    localparam int T_WALK = 3;
    localparam int T_SKIP = 4;
    localparam int T_ARST = 5;
    localparam int T_EMPT = 6;
    localparam int T_RAND = 7;
    localparam int T_HOLD = 8;

    function automatic string tag_name(input int t);
        case (t)
            T_RST:   return "reset_state";
            T_ROT:   return "all_ones_rotation";
            T_EN:    return "enable_gating";
            T_WALK:  return "walking_single";
            T_SKIP:  return "skip_non_requesters";
            T_ARST:  return "async_reset_midrun";
            T_EMPT:  return "empty_request";
            T_HOLD:  return "enable_toggle_resume";
            default: return "random";
        endcase
    endfunction

    // Scan ptr, ptr+1, ... mod 8; first requester wins. k = -1 when nothing granted.
    function automatic logic [7:0] model_gnt(input logic [7:0] r, input logic e,
                                             input logic rs, input int p, output int k);
        logic [7:0] oh;
        oh = '0;
        k  = -1;
        if (rs && e) begin
            for (int o = 0; o < 8; o++) begin
                if (k < 0 && r[(p + o) % 8]) begin
                    k = (p + o) % 8;
                end
            end
            if (k >= 0) oh[k] = 1'b1;
        end
        return oh;
    endfunction

    task automatic drive(input logic [7:0] r, input logic e, input logic rs, input int tag);
        exp_t x;
        int   k;
        @(posedge clk);
        #1;
        reset = rs;
        req   = r;
        en    = e;
        if (!rs) m_ptr = 0;
        x.exp = model_gnt(r, e, rs, m_ptr, k);
        x.tag = tag;
        q.push_back(x);
        if (k >= 0) m_ptr = (k + 1) % 8;
    endtask

    // Monitor: the grant is combinational, so it is presented every cycle at mid-period.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            n_tests++;
            if (gnt !== x.exp) begin
                n_fail++;
                $display("FAIL %s: gnt=%02h expected %02h (req=%02h en=%0b reset=%0b)",
                         tag_name(x.tag), gnt, x.exp, req, en, reset);
            end
        end
    end

    initial begin
        reset = 1'b0;
        req   = 8'h00;
        en    = 1'b0;

        repeat (2) drive(8'hFF, 1'b1, 1'b0, T_RST);

        for (int i = 0; i < 10; i++) drive(8'hFF, 1'b1, 1'b1, T_ROT);

        drive(8'hFF, 1'b1, 1'b0, T_RST);
        repeat (2) drive(8'hFF, 1'b0, 1'b1, T_EN);
        drive(8'hFF, 1'b1, 1'b1, T_EN);

        for (int i = 0; i < 8; i++) drive(8'(1 << i), 1'b1, 1'b1, T_WALK);

        drive(8'hFF, 1'b1, 1'b0, T_RST);
        repeat (3) drive(8'hFF, 1'b1, 1'b1, T_SKIP);
        repeat (2) drive(8'h81, 1'b1, 1'b1, T_SKIP);

        drive(8'hFF, 1'b1, 1'b0, T_RST);
        repeat (5) drive(8'hFF, 1'b1, 1'b1, T_ARST);
        drive(8'hFF, 1'b1, 1'b0, T_ARST);
        drive(8'hFF, 1'b1, 1'b1, T_ARST);

        repeat (3) drive(8'h00, 1'b1, 1'b1, T_EMPT);
        drive(8'hFF, 1'b1, 1'b1, T_EMPT);

        repeat (3) drive(8'hFF, 1'b1, 1'b1, T_HOLD);
        repeat (2) drive(8'hFF, 1'b0, 1'b1, T_HOLD);
        repeat (2) drive(8'hFF, 1'b1, 1'b1, T_HOLD);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            drive(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) != 0), T_RAND);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
